// File: rtl/sync_edge_pkg.sv
// ---------------------------------------------------------------------------
// sync_edge_pkg
// Shared types and default parameters for the multi-channel synchroniser /
// debounce / edge detector (sync_edge_det_multi and sync_edge_chan).
// Build option: define SYNC_EDGE_DEBOUNCE_EN to build the debounce counters.
// ---------------------------------------------------------------------------
package sync_edge_pkg;

  // Run-time edge selection; bit 0 enables rising, bit 1 enables falling.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int unsigned DEF_NUM_CH          = 4;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

  // True when a level change towards new_level is selected by mode.
  function automatic logic edge_qualifies(edge_mode_t mode, logic new_level);
    logic rise_en;
    logic fall_en;
    rise_en = (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    fall_en = (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    return new_level ? rise_en : fall_en;
  endfunction

endpackage

// File: rtl/sync_edge_chan.sv
// ---------------------------------------------------------------------------
// sync_edge_chan
// One channel: SYNC_STAGES-deep synchroniser, optional debounce filter,
// edge qualification and sticky event flag.
// Build option: SYNC_EDGE_DEBOUNCE_EN builds the debounce counter; without it
// the level follows the synchronised input every cycle.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   async_i      asynchronous input pin
//   edge_mode_i  edge selection, sampled only on the cycle the level flips
//   flag_clr_i   write-1-to-clear for flag_o (set has priority)
//   level_o      debounced, synchronised level
//   edge_o       one-cycle pulse on a qualifying level flip
//   flag_o       sticky record of a qualifying level flip
// ---------------------------------------------------------------------------
module sync_edge_chan
  import sync_edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       async_i,
  input  edge_mode_t edge_mode_i,
  input  logic       flag_clr_i,
  output logic       level_o,
  output logic       edge_o,
  output logic       flag_o
);

  // Elaboration-time sanity hook on the configuration parameters.
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || CNT_W < 1) begin : g_bad_cfg
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_c;
  logic                   level_q, level_d;
  logic                   edge_q, edge_d;
  logic                   flag_q, flag_d;

  // Synchroniser shift register; the last stage is the only one used.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_c = sync_q[SYNC_STAGES-1];

`ifdef SYNC_EDGE_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Level flips only after DEBOUNCE_CYCLES consecutive differing samples;
  // any agreeing sample restarts the count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_c != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync_c;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign level_d = sync_c;
`endif

  // Qualification and sticky flag; a coincident set beats the clear.
  always_comb begin
    edge_d = 1'b0;
    if (level_d != level_q) begin
      edge_d = edge_qualifies(edge_mode_i, level_d);
    end
    flag_d = edge_d | (flag_q & ~flag_clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      edge_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      edge_q  <= edge_d;
      flag_q  <= flag_d;
    end
  end

  assign level_o = level_q;
  assign edge_o  = edge_q;
  assign flag_o  = flag_q;

endmodule

// File: rtl/sync_edge_det_multi.sv
// ---------------------------------------------------------------------------
// sync_edge_det_multi
// NUM_CH independent synchroniser / debounce / edge-detect channels between
// board pins and the 12 MHz control domain.
// Build option: SYNC_EDGE_DEBOUNCE_EN enables the per-channel debounce filter.
//
// Ports
//   clk        system clock
//   rst        asynchronous active-high reset
//   async_in   asynchronous inputs, one bit per channel
//   edge_mode  shared mode: 00 none, 01 rising, 10 falling, 11 both
//   flag_clr   write-1-to-clear for edge_flag, per channel
//   level_out  debounced, synchronised levels
//   edge_det   one-cycle pulses on qualifying transitions
//   edge_flag  sticky qualifying-transition flags
// ---------------------------------------------------------------------------
module sync_edge_det_multi
  import sync_edge_pkg::*;
#(
  parameter int unsigned NUM_CH          = DEF_NUM_CH,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] async_in,
  input  logic [1:0]        edge_mode,
  input  logic [NUM_CH-1:0] flag_clr,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] edge_det,
  output logic [NUM_CH-1:0] edge_flag
);

  edge_mode_t mode_c;

  assign mode_c = edge_mode_t'(edge_mode);

  // One fully independent channel per input bit.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    sync_edge_chan #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .async_i     (async_in[g]),
      .edge_mode_i (mode_c),
      .flag_clr_i  (flag_clr[g]),
      .level_o     (level_out[g]),
      .edge_o      (edge_det[g]),
      .flag_o      (edge_flag[g])
    );
  end

endmodule

// File: tb/tb_sync_edge_det_multi.sv
// ---------------------------------------------------------------------------
// tb_sync_edge_det_multi
// Directed and randomised checks of sync_edge_det_multi against a reference
// model: a level flips once the last DB synchronised samples all disagree
// with it (DB = 1 when SYNC_EDGE_DEBOUNCE_EN is not defined).
// ---------------------------------------------------------------------------
module tb_sync_edge_det_multi;

  localparam int NUM_CH = 4;
  localparam int S      = 2;
  localparam int DBP    = 4;
`ifdef SYNC_EDGE_DEBOUNCE_EN
  localparam int DB = DBP;
`else
  localparam int DB = 1;
`endif
  // Steps from the first edge that samples a change to the edge that shows it.
  localparam int LAT = S + DB;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] async_in;
  logic [1:0]        edge_mode;
  logic [NUM_CH-1:0] flag_clr;
  logic [NUM_CH-1:0] level_out;
  logic [NUM_CH-1:0] edge_det;
  logic [NUM_CH-1:0] edge_flag;

  int checks = 0;
  int errors = 0;

  // Reference model state; hist[0] is the input sampled at the latest edge.
  logic [NUM_CH-1:0] hist [$];
  logic [NUM_CH-1:0] m_level;
  logic [NUM_CH-1:0] m_edge;
  logic [NUM_CH-1:0] m_flag;

  always #5 clk = ~clk;

  sync_edge_det_multi #(
    .NUM_CH          (NUM_CH),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (DBP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .async_in  (async_in),
    .edge_mode (edge_mode),
    .flag_clr  (flag_clr),
    .level_out (level_out),
    .edge_det  (edge_det),
    .edge_flag (edge_flag)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < S + DB; i++) hist.push_back('0);
    m_level = '0;
    m_edge  = '0;
    m_flag  = '0;
  endfunction

  task automatic model_edge();
    logic [NUM_CH-1:0] nl;
    logic [NUM_CH-1:0] ne;
    bit                all_diff;
    if (rst) begin
      model_reset();
      return;
    end
    hist.push_front(async_in);
    void'(hist.pop_back());
    nl = m_level;
    ne = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) begin
        if (hist[S + j][c] == m_level[c]) all_diff = 1'b0;
      end
      if (all_diff) begin
        nl[c] = ~m_level[c];
        ne[c] = nl[c] ? edge_mode[0] : edge_mode[1];
      end
    end
    m_flag  = ne | (m_flag & ~flag_clr);
    m_level = nl;
    m_edge  = ne;
  endtask

  // One clock: advance the model, then compare all outputs after the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("level_out", 32'(level_out), 32'(m_level));
    check("edge_det", 32'(edge_det), 32'(m_edge));
    check("edge_flag", 32'(edge_flag), 32'(m_flag));
  endtask

  // Steps until level_out[ch] reaches v, bounded; compares the step count.
  task automatic measure(string tag, int ch, logic v, int exp_steps);
    int n;
    n = 0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (level_out[ch] === v) begin
        n = i;
        break;
      end
    end
    check(tag, 32'(n), 32'(exp_steps));
  endtask

  initial begin
    int pulses;
    rst       = 1'b1;
    async_in  = '0;
    edge_mode = 2'b11;
    flag_clr  = '0;
    model_reset();

    // Reset state, then idle inputs in mode 11.
    step();
    step();
    rst = 1'b0;
    repeat (10) step();

    // Mode 01: rising on ch0 pulses and sets the flag; falling is silent.
    edge_mode   = 2'b01;
    async_in[0] = 1'b1;
    measure("rise_latency", 0, 1'b1, LAT);
    check("rise_pulse", 32'(edge_det[0]), 32'd1);
    check("rise_flag", 32'(edge_flag[0]), 32'd1);
    step();
    async_in[0] = 1'b0;
    measure("fall_latency", 0, 1'b0, LAT);
    check("fall_no_pulse", 32'(edge_det[0]), 32'd0);

    // Clear the ch0 flag.
    flag_clr[0] = 1'b1;
    step();
    flag_clr[0] = 1'b0;
    check("flag_cleared", 32'(edge_flag[0]), 32'd0);
    step();

    // Mode 11: simultaneous rise then fall on ch1/ch2.
    edge_mode     = 2'b11;
    async_in[2:1] = 2'b11;
    repeat (LAT) step();
    check("dual_rise", 32'(edge_det[2:1]), 32'd3);
    repeat (3) step();
    async_in[2:1] = 2'b00;
    repeat (LAT) step();
    check("dual_fall", 32'(edge_det[2:1]), 32'd3);
    repeat (3) step();

    // Mode 00: levels track with no pulses.
    edge_mode     = 2'b00;
    async_in[2:1] = 2'b11;
    repeat (LAT) step();
    check("none_level", 32'(level_out[2:1]), 32'd3);
    check("none_pulse", 32'(edge_det), 32'd0);
    async_in[2:1] = 2'b00;
    repeat (LAT + 2) step();

    // Clear coincident with a qualifying rise: set wins.
    edge_mode   = 2'b01;
    async_in[0] = 1'b1;
    repeat (LAT - 1) step();
    flag_clr[0] = 1'b1;
    step();
    flag_clr[0] = 1'b0;
    check("set_wins_pulse", 32'(edge_det[0]), 32'd1);
    check("set_wins_flag", 32'(edge_flag[0]), 32'd1);
    async_in[0] = 1'b0;
    repeat (LAT + 2) step();

    // Glitch on ch3 lasting 3 samples, then one lasting DB samples.
    edge_mode = 2'b11;
    pulses    = 0;
    async_in[3] = 1'b1;
    for (int i = 0; i < 3; i++) begin step(); pulses += int'(edge_det[3]); end
    async_in[3] = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin step(); pulses += int'(edge_det[3]); end
    check("short_glitch_pulses", 32'(pulses), (3 >= DB) ? 32'd2 : 32'd0);
    pulses = 0;
    async_in[3] = 1'b1;
    for (int i = 0; i < DB; i++) begin step(); pulses += int'(edge_det[3]); end
    async_in[3] = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin step(); pulses += int'(edge_det[3]); end
    check("full_glitch_pulses", 32'(pulses), 32'd2);

    // Reset asserted mid-pulse clears outputs asynchronously.
    edge_mode   = 2'b01;
    async_in[0] = 1'b1;
    repeat (LAT) step();
    check("pre_reset_pulse", 32'(edge_det[0]), 32'd1);
    rst = 1'b1;
    #2;
    check("async_rst_level", 32'(level_out), 32'd0);
    check("async_rst_edge", 32'(edge_det), 32'd0);
    check("async_rst_flag", 32'(edge_flag), 32'd0);
    model_reset();
    step();
    step();

    // Input already high at reset release gives a real rising transition.
    rst = 1'b0;
    measure("release_latency", 0, 1'b1, LAT);
    check("release_pulse", 32'(edge_det[0]), 32'd1);
    async_in[0] = 1'b0;
    repeat (LAT + 2) step();

    // Randomised toggling, mode changes and clears against the model.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 3) == 0) async_in[c] = ~async_in[c];
        flag_clr[c] = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 19) == 0) edge_mode = 2'($urandom_range(0, 3));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_edge_det_multi.md
# sync_edge_det_multi

Parametrised multi-channel successor to the single-input synchroniser/edge detector. Each of `NUM_CH` asynchronous inputs passes through a `SYNC_STAGES`-deep flop synchroniser and an optional debounce filter. Each channel then produces a one-cycle edge pulse, a debounced level and a sticky event flag, with the edge polarity chosen at run time. Sits between board-level pins (buttons, external strobes) and the control FSMs in the 12 MHz domain.

## Interface
- `NUM_CH`, 4, number of independent channels (≥1)
- `SYNC_STAGES`, 2, synchroniser depth (≥2)
- `DEBOUNCE_CYCLES`, 4, consecutive differing cycles required before the level flips (≥1)
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`, debounce counter width

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `async_in`  in  NUM_CH  asynchronous inputs, one bit per channel
- `edge_mode`  in  2  detection mode shared by all channels: 00 none, 01 rising, 10 falling, 11 both
- `flag_clr`  in  NUM_CH  write-1-to-clear for `edge_flag`, synchronous
- `level_out`  out  NUM_CH  debounced, synchronised level
- `edge_det`  out  NUM_CH  single-cycle pulse on a qualifying transition
- `edge_flag`  out  NUM_CH  sticky record of a qualifying transition

## Operation
- Per channel, the synchroniser shift register produces `sync`, the last stage.
- Debounce state per channel is `level_out` (stable) and counter `cnt`.
  - `sync == level_out`: `cnt` <= 0.
  - `sync != level_out` and `cnt < DEBOUNCE_CYCLES-1`: `cnt` <= `cnt`+1.
  - `sync != level_out` and `cnt == DEBOUNCE_CYCLES-1`: `level_out` <= `sync`, `cnt` <= 0.
  - A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles restarts the count and never changes `level_out`.
- Qualification happens on the cycle `level_out` flips. The transition qualifies if it is 0→1 with `edge_mode[0]`=1, or 1→0 with `edge_mode[1]`=1.
  - When a transition qualifies, `edge_det` <= 1 for exactly one cycle, on the same edge that updates `level_out`.
  - `edge_mode` is sampled only on that cycle. Changing the mode mid-count has no other effect.
- `edge_flag` is set by a qualifying transition and cleared by `flag_clr`. When set and clear coincide, set wins and the flag stays 1.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulse.
- Counter arithmetic is unsigned in `CNT_W` bits. The counter never exceeds `DEBOUNCE_CYCLES-1`, so it never wraps.

## Timing
- Reset values: all synchroniser flops, `level_out`, `cnt`, `edge_det` and `edge_flag` are 0.
- Reset asserted mid-count or mid-pulse clears state immediately and asynchronously. No pulse is emitted for a count that was aborted by reset.
- If `async_in`=1 at reset release, a rising transition follows after the normal latency. This transition is real and qualifies under mode 01/11.
- Latency: `async_in` changes and meets setup before rising edge k. `level_out` and `edge_det` update at edge k + `SYNC_STAGES` + `DEBOUNCE_CYCLES` − 1.
- `edge_flag` rises on the same edge as `edge_det`. A clear takes effect on the edge after `flag_clr` is sampled high.
- Input toggling faster than the debounce window yields no output activity.

## Configuration
- Macro `SYNC_EDGE_DEBOUNCE_EN`.
- Defined: the debounce counter is built as described above.
- Undefined: no counter is built, and `DEBOUNCE_CYCLES` and `CNT_W` are ignored. `level_out` <= `sync` every cycle, giving latency `SYNC_STAGES` edges, which is identical to the `DEBOUNCE_CYCLES`=1 behaviour.

## Structure
- Package `sync_edge_pkg` holds:
  - enum `edge_mode_t` (`EDGE_NONE`, `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH`)
  - default parameter constants
- Sub-module `sync_edge_chan` implements one channel: synchroniser, debounce, qualify and flag. It is instantiated `NUM_CH` times by a generate loop in the top.

## Test plan
- Reset, then `async_in`=4'b0000 and mode 11 for 10 cycles: all outputs stay 0. Assert `rst` mid-count on channel 0: outputs return to 0 immediately.
- Defaults, mode 01: raise ch0 before edge k. `level_out[0]`=1 and a 1-cycle `edge_det[0]` pulse appear at edge k+5, and `edge_flag[0]`=1. Lower ch0: no pulse, `level_out[0]`=0 at the corresponding edge.
- Mode 11: raise ch1 and ch2 on the same cycle: both pulse on the same edge. Drop both: both pulse again. Mode 00: no pulses, but levels still track.
- Glitch: hold ch3 high for 3 synchronised cycles with `DEBOUNCE_CYCLES`=4: `level_out[3]` stays 0 and no pulse occurs. Then hold it high for 4 cycles: the flip and pulse occur.
- Flags: after setting ch0, pulse `flag_clr[0]`: the flag is 0 the next cycle. Clear coincident with a new qualifying edge: the flag stays 1.
- With `SYNC_EDGE_DEBOUNCE_EN` undefined and `SYNC_STAGES`=3: an edge before edge k gives a pulse at edge k+3, and a 1-cycle glitch propagates as a flip plus pulse.
